config_loader: RTL and testbench

- Sits directly upstream of the fabric top's serial configuration chain.
- Accepts a bitstream as a byte stream over a valid/ready handshake and serializes it onto prog_in/prog_clk/prog_en.
- Checks a CRC-16 trailer against the bits actually shifted, then releases prog_en so the fabric leaves programming mode.
- One loader per fabric instance; prog_out from the chain end is monitored only for a continuity check.

---
 rtl/config_loader_if.sv | 27 ++
 rtl/config_loader.sv | 246 ++++++++++++++++++++++++
 tb/tb_config_loader.sv | 306 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/config_loader_if.sv
// ----------------------------------------------------------------------------
// config_loader_if
// Byte-stream handshake between a bitstream source and config_loader.
//   in_data  [7:0] : bitstream byte, MSB is shifted into the chain first
//   in_valid       : source has a byte on in_data
//   in_ready       : loader takes in_data on this rising clock edge
// A byte transfers on a rising edge where in_valid and in_ready are both 1.
// ----------------------------------------------------------------------------
interface config_loader_if;
   logic [7:0] in_data;
   logic       in_valid;
   logic       in_ready;

   // Byte source side
   modport master (
      output in_data,
      output in_valid,
      input  in_ready
   );

   // Loader side
   modport slave (
      input  in_data,
      input  in_valid,
      output in_ready
   );
endinterface

// File: rtl/config_loader.sv
// ----------------------------------------------------------------------------
// config_loader
// Takes a configuration bitstream as bytes and shifts it, bit by bit, into the
// fabric's serial configuration chain. A CRC-16-CCITT is computed over the
// bits actually shifted and compared against a two-byte trailer (high byte
// first). prog_en is held high for the whole load and dropped when the trailer
// has been checked, which returns the fabric to operation.
//
// Ports
//   clk       : system clock, rising edge
//   rst_n     : asynchronous active-low reset
//   start     : one-cycle pulse, begins a load (ignored while a load runs)
//   in_bus    : byte handshake (slave side of config_loader_if)
//   prog_in   : serial data to the chain head
//   prog_clk  : chain shift clock, idles low
//   prog_en   : high for the whole load
//   prog_out  : chain tail, sampled for a continuity observation only
//   busy      : load in progress
//   done      : sticky, last load passed the CRC check
//   error     : sticky, last load failed the CRC check
//   crc_out   : CRC over the shifted bits
// ----------------------------------------------------------------------------
module config_loader #(
   parameter int CHAIN_BITS = 25,
   parameter int HALF_PER   = 1,
   parameter int CNT_W      = 16
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 start,
   config_loader_if.slave       in_bus,
   output logic                 prog_in,
   output logic                 prog_clk,
   output logic                 prog_en,
   input  logic                 prog_out,
   output logic                 busy,
   output logic                 done,
   output logic                 error,
   output logic [15:0]          crc_out
);

   localparam logic [2:0] S_IDLE  = 3'd0;
   localparam logic [2:0] S_FETCH = 3'd1;
   localparam logic [2:0] S_LO    = 3'd2;
   localparam logic [2:0] S_HI    = 3'd3;
   localparam logic [2:0] S_CRCH  = 3'd4;
   localparam logic [2:0] S_CRCL  = 3'd5;
   localparam logic [2:0] S_CHECK = 3'd6;

   localparam int              HW        = (HALF_PER > 1) ? $clog2(HALF_PER) : 1;
   localparam logic [HW-1:0]   HALF_LAST = HW'(HALF_PER - 1);
   localparam logic [CNT_W-1:0] CHAIN_C  = CNT_W'(CHAIN_BITS);

   // One serial step of CRC-16-CCITT (poly 0x1021), MSB first, unreflected.
   function automatic logic [15:0] crc_step(input logic [15:0] c, input logic b);
      logic fb;
      fb = c[15] ^ b;
      crc_step = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
   endfunction

   logic [2:0]       state_q, state_d;
   logic [CNT_W-1:0] cnt_q, cnt_d;
   logic [15:0]      crc_q, crc_d;
   logic [7:0]       sr_q, sr_d;
   logic [3:0]       bits_q, bits_d;
   logic [HW-1:0]    half_q, half_d;
   logic [7:0]       trl_q, trl_d;
   logic             prog_in_q, prog_in_d;
   logic             prog_clk_q, prog_clk_d;
   logic             prog_en_q, prog_en_d;
   logic             busy_q, busy_d;
   logic             done_q, done_d;
   logic             error_q, error_d;
   logic             loaded_q, loaded_d;
   logic             pout_q;
   logic             tog_q, tog_d;

   logic             in_ready_w;
   logic             xfer;
   logic [CNT_W-1:0] rem;
   logic [3:0]       bits_first;
   logic             cont_unused;

   assign in_ready_w      = (state_q == S_FETCH) || (state_q == S_CRCH) || (state_q == S_CRCL);
   assign in_bus.in_ready = in_ready_w;
   assign xfer            = in_bus.in_valid && in_ready_w;

   // Bits still owed to the chain; the last byte may be only partly used.
   assign rem        = CHAIN_C - cnt_q;
   assign bits_first = (32'(rem) >= 8) ? 4'd8 : 4'(rem);

   // Chain continuity is observed only; a silent prog_out has no consequence.
   assign cont_unused = tog_q;

   always_comb begin
      state_d    = state_q;
      cnt_d      = cnt_q;
      crc_d      = crc_q;
      sr_d       = sr_q;
      bits_d     = bits_q;
      half_d     = half_q;
      trl_d      = trl_q;
      prog_in_d  = prog_in_q;
      prog_clk_d = prog_clk_q;
      prog_en_d  = prog_en_q;
      busy_d     = busy_q;
      done_d     = done_q;
      error_d    = error_q;
      loaded_d   = loaded_q;
      tog_d      = tog_q;

      if (busy_q && (prog_out ^ pout_q)) begin
         tog_d = 1'b1;
      end

      case (state_q)
         S_IDLE: begin
            if (start) begin
               done_d    = 1'b0;
               error_d   = 1'b0;
               crc_d     = 16'hFFFF;
               cnt_d     = '0;
               prog_en_d = 1'b1;
               busy_d    = 1'b1;
               loaded_d  = 1'b1;
               tog_d     = 1'b0;
               state_d   = S_FETCH;
            end
         end
         S_FETCH: begin
            if (xfer) begin
               sr_d      = in_bus.in_data;
               bits_d    = bits_first;
               prog_in_d = in_bus.in_data[7];
               half_d    = '0;
               state_d   = S_LO;
            end
         end
         S_LO: begin
            if (half_q == HALF_LAST) begin
               // Rising edge of prog_clk: the bit on prog_in is committed.
               half_d     = '0;
               prog_clk_d = 1'b1;
               crc_d      = crc_step(crc_q, sr_q[7]);
               cnt_d      = cnt_q + CNT_W'(1);
               sr_d       = {sr_q[6:0], 1'b0};
               bits_d     = bits_q - 4'd1;
               state_d    = S_HI;
            end else begin
               half_d = half_q + HW'(1);
            end
         end
         S_HI: begin
            if (half_q == HALF_LAST) begin
               // prog_in may only move together with the falling edge.
               half_d     = '0;
               prog_clk_d = 1'b0;
               if (cnt_q == CHAIN_C) begin
                  state_d = S_CRCH;
               end else if (bits_q == 4'd0) begin
                  state_d = S_FETCH;
               end else begin
                  prog_in_d = sr_q[7];
                  state_d   = S_LO;
               end
            end else begin
               half_d = half_q + HW'(1);
            end
         end
         S_CRCH: begin
            if (xfer) begin
               trl_d   = in_bus.in_data;
               state_d = S_CRCL;
            end
         end
         S_CRCL: begin
            // Verdict is registered here so it is visible during CHECK.
            if (xfer) begin
               if ({trl_q, in_bus.in_data} == crc_q) begin
                  done_d = 1'b1;
               end else begin
                  error_d = 1'b1;
               end
               prog_en_d  = 1'b0;
               busy_d     = 1'b0;
               prog_clk_d = 1'b0;
               state_d    = S_CHECK;
            end
         end
         S_CHECK: begin
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q    <= S_IDLE;
         cnt_q      <= '0;
         crc_q      <= 16'hFFFF;
         sr_q       <= '0;
         bits_q     <= '0;
         half_q     <= '0;
         trl_q      <= '0;
         prog_in_q  <= 1'b0;
         prog_clk_q <= 1'b0;
         prog_en_q  <= 1'b0;
         busy_q     <= 1'b0;
         done_q     <= 1'b0;
         error_q    <= 1'b0;
         loaded_q   <= 1'b0;
         pout_q     <= 1'b0;
         tog_q      <= 1'b0;
      end else begin
         state_q    <= state_d;
         cnt_q      <= cnt_d;
         crc_q      <= crc_d;
         sr_q       <= sr_d;
         bits_q     <= bits_d;
         half_q     <= half_d;
         trl_q      <= trl_d;
         prog_in_q  <= prog_in_d;
         prog_clk_q <= prog_clk_d;
         prog_en_q  <= prog_en_d;
         busy_q     <= busy_d;
         done_q     <= done_d;
         error_q    <= error_d;
         loaded_q   <= loaded_d;
         pout_q     <= prog_out;
         tog_q      <= tog_d;
      end
   end

   assign prog_in  = prog_in_q;
   assign prog_clk = prog_clk_q;
   assign prog_en  = prog_en_q;
   assign busy     = busy_q;
   assign done     = done_q;
   assign error    = error_q;
   // The CRC register idles at FFFF; the port reads 0 until a load has begun.
   assign crc_out  = loaded_q ? crc_q : 16'h0000;

endmodule

// File: tb/tb_config_loader.sv
module tb_config_loader;

   logic clk = 1'b0;
   always #5 clk = ~clk;

   logic       rst_n   = 1'b0;
   logic       start_r = 1'b0;
   logic [7:0] data_r  = 8'h00;
   logic       valid_r = 1'b0;
   int         sel     = 0;
   logic       mon_clr = 1'b0;

   int n_tests = 0;
   int n_fail  = 0;

   config_loader_if ifa ();
   config_loader_if ifb ();

   assign ifa.in_data  = data_r;
   assign ifb.in_data  = data_r;
   assign ifa.in_valid = valid_r && (sel == 0);
   assign ifb.in_valid = valid_r && (sel == 1);

   logic sa, sb;
   assign sa = start_r && (sel == 0);
   assign sb = start_r && (sel == 1);

   logic a_pin, a_pclk, a_pen, a_busy, a_done, a_err;
   logic b_pin, b_pclk, b_pen, b_busy, b_done, b_err;
   logic [15:0] a_crc, b_crc;

   config_loader #(.CHAIN_BITS(20), .HALF_PER(1), .CNT_W(16)) u_a (
      .clk(clk), .rst_n(rst_n), .start(sa), .in_bus(ifa),
      .prog_in(a_pin), .prog_clk(a_pclk), .prog_en(a_pen), .prog_out(a_pin),
      .busy(a_busy), .done(a_done), .error(a_err), .crc_out(a_crc)
   );

   config_loader #(.CHAIN_BITS(20), .HALF_PER(3), .CNT_W(16)) u_b (
      .clk(clk), .rst_n(rst_n), .start(sb), .in_bus(ifb),
      .prog_in(b_pin), .prog_clk(b_pclk), .prog_en(b_pen), .prog_out(b_pin),
      .busy(b_busy), .done(b_done), .error(b_err), .crc_out(b_crc)
   );

   // Selected-DUT views
   logic        pin_s, pclk_s, pen_s, busy_s, done_s, err_s, rdy_s;
   logic [15:0] crc_s;
   assign pin_s  = (sel == 1) ? b_pin  : a_pin;
   assign pclk_s = (sel == 1) ? b_pclk : a_pclk;
   assign pen_s  = (sel == 1) ? b_pen  : a_pen;
   assign busy_s = (sel == 1) ? b_busy : a_busy;
   assign done_s = (sel == 1) ? b_done : a_done;
   assign err_s  = (sel == 1) ? b_err  : a_err;
   assign rdy_s  = (sel == 1) ? ifb.in_ready : ifa.in_ready;
   assign crc_s  = (sel == 1) ? b_crc  : a_crc;

   // Chain-side monitor, one lane per DUT
   logic [1:0] pclk_v, pin_v;
   assign pclk_v = {b_pclk, a_pclk};
   assign pin_v  = {b_pin, a_pin};

   int          rises [2];
   int          hmin [2], hmax [2], lmin [2], stabmin [2], viol [2], run [2], stab [2];
   logic [31:0] bitsr [2];
   logic        prevc [2], previ [2];

   initial begin
      for (int i = 0; i < 2; i++) begin
         rises[i] = 0; hmin[i] = 99; hmax[i] = 0; lmin[i] = 99; stabmin[i] = 99;
         viol[i] = 0; run[i] = 0; stab[i] = 0; bitsr[i] = 0; prevc[i] = 0; previ[i] = 0;
      end
   end

   always @(negedge clk) begin
      for (int i = 0; i < 2; i++) begin
         if (mon_clr) begin
            rises[i] = 0; hmin[i] = 99; hmax[i] = 0; lmin[i] = 99; stabmin[i] = 99;
            viol[i] = 0; run[i] = 0; stab[i] = 0; bitsr[i] = 0;
         end else begin
            if (pclk_v[i] != prevc[i]) begin
               if (prevc[i]) begin
                  if (run[i] < hmin[i]) hmin[i] = run[i];
                  if (run[i] > hmax[i]) hmax[i] = run[i];
               end else begin
                  if (rises[i] > 0 && run[i] < lmin[i]) lmin[i] = run[i];
                  rises[i] = rises[i] + 1;
                  bitsr[i] = {bitsr[i][30:0], pin_v[i]};
                  if (stab[i] < stabmin[i]) stabmin[i] = stab[i];
               end
               run[i] = 1;
            end else begin
               run[i] = run[i] + 1;
            end
            if (pin_v[i] != previ[i]) begin
               if (pclk_v[i]) viol[i] = viol[i] + 1;
               stab[i] = 1;
            end else begin
               stab[i] = stab[i] + 1;
            end
         end
         prevc[i] = pclk_v[i];
         previ[i] = pin_v[i];
      end
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_tests++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h", nm, act, exp);
      end
   endtask

   function automatic logic [15:0] crc_model(input logic [19:0] bits);
      logic [15:0] c;
      logic        fb;
      c = 16'hFFFF;
      for (int i = 19; i >= 0; i--) begin
         fb = c[15] ^ bits[i];
         c  = {c[14:0], 1'b0} ^ (fb ? 16'h1021 : 16'h0000);
      end
      return c;
   endfunction

   task automatic send_byte(input logic [7:0] b, input string nm);
      int n;
      n = 0;
      @(negedge clk);
      data_r  = b;
      valid_r = 1'b1;
      while (!rdy_s && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk({nm, "_ready_timeout"}, 32'd1, 32'd0);
      @(posedge clk);
      #1 valid_r = 1'b0;
   endtask

   task automatic run_load(input int s, input logic [7:0] b0, input logic [7:0] b1,
                           input logic [7:0] b2, input logic [15:0] trl,
                           input int stall, input int ms, input string nm);
      int n, hi, r0;
      sel = s;
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
      @(negedge clk);
      start_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      chk({nm, "_busy_start"}, 32'(busy_s), 32'd1);
      chk({nm, "_pen_start"}, 32'(pen_s), 32'd1);
      send_byte(b0, nm);
      if (ms != 0) begin
         @(negedge clk);
         start_r = 1'b1;
         @(negedge clk);
         start_r = 1'b0;
      end
      if (stall > 0) begin
         n = 0;
         @(negedge clk);
         while (!rdy_s && n < 400) begin
            @(negedge clk);
            n++;
         end
         if (n >= 400) chk({nm, "_stall_timeout"}, 32'd1, 32'd0);
         r0 = rises[s];
         hi = 0;
         repeat (stall) begin
            @(negedge clk);
            if (pclk_s) hi++;
         end
         chk({nm, "_stall_pclk_high"}, 32'(hi), 32'd0);
         chk({nm, "_stall_rises"}, 32'(rises[s]), 32'(r0));
      end
      send_byte(b1, nm);
      send_byte(b2, nm);
      send_byte(trl[15:8], nm);
      n = 0;
      @(negedge clk);
      data_r  = trl[7:0];
      valid_r = 1'b1;
      while (!rdy_s && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk({nm, "_last_timeout"}, 32'd1, 32'd0);
      chk({nm, "_pen_before_check"}, 32'(pen_s), 32'd1);
      @(posedge clk);
      #1 valid_r = 1'b0;
      chk({nm, "_pen_in_check"}, 32'(pen_s), 32'd0);
      chk({nm, "_busy_in_check"}, 32'(busy_s), 32'd0);
      if (ms != 0) begin
         start_r = 1'b1;
         @(posedge clk);
         #1 start_r = 1'b0;
         @(negedge clk);
         chk({nm, "_start_at_check_busy"}, 32'(busy_s), 32'd0);
         chk({nm, "_start_at_check_pen"}, 32'(pen_s), 32'd0);
      end
   endtask

   typedef struct {
      int          s;
      logic [7:0]  b0, b1, b2;
      logic [15:0] tx;
      int          stall;
      int          ms;
      logic        d, e;
      logic [19:0] bits;
      int          hp;
   } vec_t;

   vec_t vt [6];

   initial begin
      logic [15:0] trl, exp_crc;
      string       nm;
      int          n;

      vt[0] = '{s:0, b0:8'hA5, b1:8'h3C, b2:8'hF0, tx:16'h0000, stall:0, ms:0, d:1'b1, e:1'b0, bits:20'hA53CF, hp:1};
      vt[1] = '{s:0, b0:8'hA5, b1:8'h3C, b2:8'hF0, tx:16'h0001, stall:0, ms:0, d:1'b0, e:1'b1, bits:20'hA53CF, hp:1};
      vt[2] = '{s:0, b0:8'hA5, b1:8'h3C, b2:8'hF0, tx:16'h0000, stall:7, ms:0, d:1'b1, e:1'b0, bits:20'hA53CF, hp:1};
      vt[3] = '{s:1, b0:8'hA5, b1:8'h3C, b2:8'hF0, tx:16'h0000, stall:0, ms:0, d:1'b1, e:1'b0, bits:20'hA53CF, hp:3};
      vt[4] = '{s:0, b0:8'h00, b1:8'hFF, b2:8'h5A, tx:16'h0000, stall:0, ms:0, d:1'b1, e:1'b0, bits:20'h00FF5, hp:1};
      vt[5] = '{s:0, b0:8'hFF, b1:8'hFF, b2:8'hFF, tx:16'h8000, stall:0, ms:1, d:1'b0, e:1'b1, bits:20'hFFFFF, hp:1};

      // Reset state
      #12;
      chk("rst_a_outputs", {a_pin, a_pclk, a_pen, a_busy, a_done, a_err, ifa.in_ready}, 7'd0);
      chk("rst_a_crc", 32'(a_crc), 32'd0);
      chk("rst_b_outputs", {b_pin, b_pclk, b_pen, b_busy, b_done, b_err, ifb.in_ready}, 7'd0);
      @(negedge clk);
      rst_n = 1'b1;
      repeat (2) @(negedge clk);
      chk("idle_in_ready", 32'(ifa.in_ready), 32'd0);

      for (int v = 0; v < 6; v++) begin
         nm      = $sformatf("v%0d", v);
         exp_crc = crc_model(vt[v].bits);
         trl     = exp_crc ^ vt[v].tx;
         run_load(vt[v].s, vt[v].b0, vt[v].b1, vt[v].b2, trl, vt[v].stall, vt[v].ms, nm);
         repeat (4) @(negedge clk);
         chk({nm, "_done"}, 32'(done_s), 32'(vt[v].d));
         chk({nm, "_error"}, 32'(err_s), 32'(vt[v].e));
         chk({nm, "_busy_after"}, 32'(busy_s), 32'd0);
         chk({nm, "_pen_after"}, 32'(pen_s), 32'd0);
         chk({nm, "_pclk_after"}, 32'(pclk_s), 32'd0);
         chk({nm, "_ready_after"}, 32'(rdy_s), 32'd0);
         chk({nm, "_rises"}, 32'(rises[vt[v].s]), 32'd20);
         chk({nm, "_bits"}, 32'(bitsr[vt[v].s][19:0]), 32'(vt[v].bits));
         chk({nm, "_crc_out"}, 32'(crc_s), 32'(exp_crc));
         chk({nm, "_high_min"}, 32'(hmin[vt[v].s]), 32'(vt[v].hp));
         chk({nm, "_high_max"}, 32'(hmax[vt[v].s]), 32'(vt[v].hp));
         chk({nm, "_low_ge_half"}, 32'(lmin[vt[v].s] >= vt[v].hp), 32'd1);
         chk({nm, "_setup_ge_half"}, 32'(stabmin[vt[v].s] >= vt[v].hp), 32'd1);
         chk({nm, "_pin_move_while_high"}, 32'(viol[vt[v].s]), 32'd0);
      end

      // Reset in the middle of a load
      sel = 0;
      mon_clr = 1'b1;
      @(negedge clk);
      #1 mon_clr = 1'b0;
      @(negedge clk);
      start_r = 1'b1;
      @(negedge clk);
      start_r = 1'b0;
      send_byte(8'hA5, "rml");
      send_byte(8'h3C, "rml");
      n = 0;
      while (rises[0] < 9 && n < 400) begin
         @(negedge clk);
         n++;
      end
      if (n >= 400) chk("rml_bit9_timeout", 32'd1, 32'd0);
      chk("rml_pen_before", 32'(a_pen), 32'd1);
      @(posedge clk);
      #2 rst_n = 1'b0;
      #1;
      chk("rml_outputs_zero", {a_pin, a_pclk, a_pen, a_busy, a_done, a_err, ifa.in_ready}, 7'd0);
      chk("rml_crc_zero", 32'(a_crc), 32'd0);
      @(negedge clk);
      rst_n = 1'b1;
      exp_crc = crc_model(20'hA53CF);
      run_load(0, 8'hA5, 8'h3C, 8'hF0, exp_crc, 0, 0, "rml_reload");
      repeat (2) @(negedge clk);
      chk("rml_reload_done", 32'(a_done), 32'd1);
      chk("rml_reload_error", 32'(a_err), 32'd0);
      chk("rml_reload_rises", 32'(rises[0]), 32'd20);
      chk("rml_reload_crc", 32'(a_crc), 32'(exp_crc));

      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
      $finish;
   end

   // Global guard against a stuck run
   initial begin
      #500000;
      $display("FAIL global_timeout: got hang expected finish");
      $display("[TB] %0d tests run, %0d failed", n_tests, n_fail + 1);
      $fatal(1, "timeout");
   end

endmodule
